// File: rtl/alu_nibble_sequencer.sv
// alu_nibble_sequencer
// Runs a WIDTH-bit operation through an external 4-bit ALU slice. It handles
// one nibble per cycle, from least significant to most significant, and
// chains the carry from each nibble into the next.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start                request an operation (accepted only in IDLE)
//   op_s, op_m, cin      function select, mode (1 = logic), carry-in
//   opa, opb             WIDTH-bit operands
//   busy, done           busy = processing nibbles; done = 1-cycle completion pulse
//   result, cout, zero   assembled result, final slice carry, result == 0
//   alu_a, alu_b         nibble operands sent to the slice
//   alu_s, alu_m, alu_ci control and carry sent to the slice
//   alu_f, alu_co        combinational result and carry returned by the slice
module alu_nibble_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op_s,
  input  logic             op_m,
  input  logic             cin,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [1:0]       alu_s,
  output logic             alu_m,
  output logic             alu_ci,
  input  logic [3:0]       alu_f,
  input  logic             alu_co
);

  localparam int N  = WIDTH / 4;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [WIDTH-1:0]  opa_q, opa_d;
  logic [WIDTH-1:0]  opb_q, opb_d;
  logic [1:0]        op_s_q, op_s_d;
  logic              op_m_q, op_m_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              cout_q, cout_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      k_q      <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      op_s_q   <= '0;
      op_m_q   <= 1'b0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      op_s_q   <= op_s_d;
      op_m_q   <= op_m_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    op_s_d   = op_s_q;
    op_m_d   = op_m_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    busy     = 1'b0;
    done     = 1'b0;
    alu_a    = '0;
    alu_b    = '0;
    alu_ci   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          opa_d   = opa;
          opb_d   = opb;
          op_s_d  = op_s;
          op_m_d  = op_m;
          carry_d = cin;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        busy   = 1'b1;
        alu_a  = opa_q[{k_q, 2'b00} +: 4];
        alu_b  = opb_q[{k_q, 2'b00} +: 4];
        alu_ci = carry_q;
        result_d[{k_q, 2'b00} +: 4] = alu_f;
        // The slice inverts its carry-out in the s[1]=1 arithmetic modes.
        // XOR with s[1] gives a true carry to chain into the next nibble.
        carry_d = alu_co ^ op_s_q[1];
        if (k_q == KW'(N - 1)) begin
          cout_d  = alu_co;
          k_d     = '0;
          state_d = DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign alu_s  = op_s_q;
  assign alu_m  = op_m_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign zero   = (result_q == '0);

endmodule
